l2_req_arbiter: RTL and testbench

Shares the single request port of the non-blocking L2_cache among NREQ load/store-queue requesters. Each requester gets a one-entry holding register. Held requests are granted round-robin into a registered cache-side output stage, and the cache id is tagged with the requester index. Cache responses are demultiplexed back to the owning requester, and a per-requester outstanding-request limit is enforced.

---
 rtl/l2_req_arbiter_if.sv | 38 +++
 rtl/l2_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_l2_req_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_req_arbiter_if.sv
// l2_req_arbiter_if: requester, response and cache-side signals of l2_req_arbiter
// master = requesters plus cache (drives *_i), slave = arbiter (drives *_o).
// L2_ARB_PERF_CNT_EN adds perf_grant_o / perf_stall_o.
interface l2_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int REQ_ID_W = 3,
  parameter int IW = $clog2(NREQ)
);
  logic [NREQ-1:0] req_valid_i, req_rw_i, req_stall_o, rsp_ready_o;
  logic [NREQ*32-1:0] req_addr_i, req_data_i;
  logic [NREQ*REQ_ID_W-1:0] req_id_i;
  logic [31:0] rsp_data_o, c_addr_o, c_data_o, c_data_i;
  logic [REQ_ID_W-1:0] rsp_id_o;
  logic c_valid_o, c_rw_o, c_stall_i, c_ready_i, err_o;
  logic [IW+REQ_ID_W-1:0] c_id_o, c_id_i;
`ifdef L2_ARB_PERF_CNT_EN
  logic [NREQ*16-1:0] perf_grant_o;
  logic [15:0] perf_stall_o;
`endif
  modport master (
    output req_valid_i, req_rw_i, req_addr_i, req_data_i, req_id_i,
    output c_stall_i, c_ready_i, c_data_i, c_id_i,
    input req_stall_o, rsp_ready_o, rsp_data_o, rsp_id_o,
    input c_valid_o, c_rw_o, c_addr_o, c_data_o, c_id_o, err_o
`ifdef L2_ARB_PERF_CNT_EN
    , input perf_grant_o, perf_stall_o
`endif
  );
  modport slave (
    input req_valid_i, req_rw_i, req_addr_i, req_data_i, req_id_i,
    input c_stall_i, c_ready_i, c_data_i, c_id_i,
    output req_stall_o, rsp_ready_o, rsp_data_o, rsp_id_o,
    output c_valid_o, c_rw_o, c_addr_o, c_data_o, c_id_o, err_o
`ifdef L2_ARB_PERF_CNT_EN
    , output perf_grant_o, perf_stall_o
`endif
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin sharing of one L2 request port among NREQ requesters
// Ports: clk; reset (async, active-low); bus (l2_req_arbiter_if.slave) carrying the
// per-requester request/stall inputs, broadcast response outputs, the registered
// cache request stage, cache response inputs and the sticky err_o.
// Optional: define L2_ARB_PERF_CNT_EN for saturating grant/stall perf counters.
module l2_req_arbiter #(
  parameter int NREQ = 4,
  parameter int REQ_ID_W = 3,
  parameter int MAX_OUT = 4,
  localparam int IW = $clog2(NREQ),
  localparam int TW = IW + REQ_ID_W
) (
  input logic clk,
  input logic reset,
  l2_req_arbiter_if.slave bus
);
  logic [NREQ-1:0] r_hv, r_rw, r_rsp_rdy;
  logic [NREQ-1:0][31:0] r_addr, r_data;
  logic [NREQ-1:0][REQ_ID_W-1:0] r_id;
  logic [NREQ-1:0][3:0] r_cnt;
  logic [IW-1:0] r_ptr;
  logic r_cv, r_crw, r_err;
  logic [31:0] r_caddr, r_cdata, r_rsp_data;
  logic [TW-1:0] r_cid;
  logic [REQ_ID_W-1:0] r_rsp_id;
  logic w_free, w_acc, w_any, w_fire;
  logic [IW-1:0] w_win, w_cown, w_rown;
  logic [NREQ-1:0] w_cap, w_pend, w_elig, w_inc, w_dec, w_gnt;

  assign w_cown = r_cid[TW-1:REQ_ID_W];
  assign w_rown = bus.c_id_i[TW-1:REQ_ID_W];
  assign w_acc = r_cv && !bus.c_stall_i;
  assign w_free = !r_cv || !bus.c_stall_i;
  assign w_cap = bus.req_valid_i & ~r_hv;

  // The request sitting in the output stage counts against its owner's limit
  always_comb begin
    w_pend = '0;
    w_elig = '0;
    w_inc = '0;
    w_dec = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pend[k] = r_cv && w_cown == IW'(k);
      w_elig[k] = r_hv[k] && ({1'b0, r_cnt[k]} + 5'(w_pend[k])) < 5'(MAX_OUT);
      w_inc[k] = w_acc && w_cown == IW'(k);
      w_dec[k] = bus.c_ready_i && w_rown == IW'(k);
    end
  end

  // Priority search from the RR pointer; IW-bit addition wraps because NREQ is a power of 2
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!w_any && w_elig[r_ptr + IW'(i)]) begin
        w_any = 1'b1;
        w_win = r_ptr + IW'(i);
      end
    w_fire = w_any && w_free;
    w_gnt = w_fire ? NREQ'(1) << w_win : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hv <= '0;
      r_rw <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_id <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_cap[k]) begin
          r_hv[k] <= 1'b1;
          r_rw[k] <= bus.req_rw_i[k];
          r_addr[k] <= bus.req_addr_i[32*k +: 32];
          r_data[k] <= bus.req_data_i[32*k +: 32];
          r_id[k] <= bus.req_id_i[REQ_ID_W*k +: REQ_ID_W];
        end else if (w_gnt[k]) begin
          r_hv[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cv <= 1'b0;
      r_crw <= 1'b0;
      r_caddr <= '0;
      r_cdata <= '0;
      r_cid <= '0;
      r_ptr <= '0;
    end else if (w_fire) begin
      r_cv <= 1'b1;
      r_crw <= r_rw[w_win];
      r_caddr <= r_addr[w_win];
      r_cdata <= r_data[w_win];
      r_cid <= {w_win, r_id[w_win]};
      r_ptr <= w_win + IW'(1);
    end else if (w_free) begin
      r_cv <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_inc[k] && !w_dec[k]) begin
          r_cnt[k] <= r_cnt[k] + 4'd1;
        end else if (w_dec[k] && !w_inc[k]) begin
          if (r_cnt[k] == '0) r_err <= 1'b1;
          else r_cnt[k] <= r_cnt[k] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_rdy <= '0;
      r_rsp_data <= '0;
      r_rsp_id <= '0;
    end else begin
      r_rsp_rdy <= bus.c_ready_i ? NREQ'(1) << w_rown : '0;
      if (bus.c_ready_i) begin
        r_rsp_data <= bus.c_data_i;
        r_rsp_id <= bus.c_id_i[REQ_ID_W-1:0];
      end
    end
  end

`ifdef L2_ARB_PERF_CNT_EN
  logic [NREQ-1:0][15:0] r_pg;
  logic [15:0] r_ps;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pg <= '0;
      r_ps <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (w_gnt[k] && r_pg[k] != 16'hFFFF) r_pg[k] <= r_pg[k] + 16'd1;
      if (r_cv && bus.c_stall_i && r_ps != 16'hFFFF) r_ps <= r_ps + 16'd1;
    end
  end
  assign bus.perf_grant_o = r_pg;
  assign bus.perf_stall_o = r_ps;
`endif

  assign bus.req_stall_o = r_hv;
  assign bus.c_valid_o = r_cv;
  assign bus.c_rw_o = r_crw;
  assign bus.c_addr_o = r_caddr;
  assign bus.c_data_o = r_cdata;
  assign bus.c_id_o = r_cid;
  assign bus.rsp_ready_o = r_rsp_rdy;
  assign bus.rsp_data_o = r_rsp_data;
  assign bus.rsp_id_o = r_rsp_id;
  assign bus.err_o = r_err;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed plus randomized scoreboard bench for l2_req_arbiter
module tb_l2_req_arbiter;
  localparam int NREQ = 4;
  localparam int RW = 3;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  l2_req_arbiter_if #(.NREQ(NREQ), .REQ_ID_W(RW)) bus ();
  l2_req_arbiter #(.NREQ(NREQ), .REQ_ID_W(RW), .MAX_OUT(MAXO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [69:0] exp_q[$];
  logic [38:0] rsp_q[$];
  logic [4:0] outs[$];
  int inflight[NREQ];
  int m_k, m_hit, m_r;
  logic [69:0] m_e;
  logic [38:0] m_rsp;
  logic [3:0] m_oh;
  bit f;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  // Monitor: requests expected in capture order per requester, responses one cycle after c_ready_i
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREQ; k++)
        if (bus.req_valid_i[k] && !bus.req_stall_o[k])
          exp_q.push_back({2'(k), bus.req_rw_i[k], bus.req_addr_i[32*k +: 32],
                           bus.req_data_i[32*k +: 32], bus.req_id_i[RW*k +: RW]});
      if (bus.c_valid_o && !bus.c_stall_i) begin
        m_k = int'(bus.c_id_o[4:3]);
        m_hit = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          m_e = exp_q[i];
          if (m_hit < 0 && int'(m_e[69:68]) == m_k) m_hit = i;
        end
        if (m_hit < 0) begin
          n_chk++;
          n_err++;
          $display("FAIL req_unexpected: got owner %0d id %h, required no request", m_k, bus.c_id_o);
        end else begin
          m_e = exp_q[m_hit];
          check("req_match", 72'({bus.c_rw_o, bus.c_addr_o, bus.c_data_o, bus.c_id_o[2:0]}), 72'(m_e[67:0]));
          exp_q.delete(m_hit);
        end
        check("out_limit", 72'(inflight[m_k] < MAXO), 72'(1));
        inflight[m_k]++;
        outs.push_back(bus.c_id_o);
      end
      if (rsp_q.size() > 0) begin
        m_rsp = rsp_q.pop_front();
        check("rsp_match", 72'({bus.rsp_ready_o, bus.rsp_id_o, bus.rsp_data_o}), 72'(m_rsp));
      end else if (bus.rsp_ready_o != '0) begin
        n_chk++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_ready %b, required 0000", bus.rsp_ready_o);
      end
      if (bus.c_ready_i) begin
        m_r = int'(bus.c_id_i[4:3]);
        m_oh = 4'b0001 << m_r;
        rsp_q.push_back({m_oh, bus.c_id_i[2:0], bus.c_data_i});
        if (inflight[m_r] > 0) inflight[m_r]--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rsp_q.delete();
    outs.delete();
    for (int k = 0; k < NREQ; k++) inflight[k] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_sb();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_req(input int k, input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] id);
    bus.req_valid_i[k] = 1'b1;
    bus.req_rw_i[k] = rw;
    bus.req_addr_i[32*k +: 32] = a;
    bus.req_data_i[32*k +: 32] = d;
    bus.req_id_i[RW*k +: RW] = id;
  endtask

  task automatic wait_owner(input int k, output bit found);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.c_valid_o && int'(bus.c_id_o[4:3]) == k) found = 1'b1;
      else tick();
    end
  endtask

  task automatic drive_random(input bit gen);
    int idx;
    for (int k = 0; k < NREQ; k++)
      if (!bus.req_stall_o[k]) begin
        bus.req_valid_i[k] = gen && ($urandom_range(0, 99) < 40);
        bus.req_rw_i[k] = 1'($urandom);
        bus.req_addr_i[32*k +: 32] = $urandom;
        bus.req_data_i[32*k +: 32] = $urandom;
        bus.req_id_i[RW*k +: RW] = 3'($urandom_range(0, 7));
      end
    bus.c_stall_i = $urandom_range(0, 99) < 25;
    bus.c_data_i = $urandom;
    bus.c_id_i = 5'($urandom);
    if (outs.size() > 0 && $urandom_range(0, 99) < (gen ? 30 : 100)) begin
      idx = $urandom_range(0, outs.size() - 1);
      bus.c_ready_i = 1'b1;
      bus.c_id_i = outs[idx];
      outs.delete(idx);
    end else begin
      bus.c_ready_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid_i = '0;
    bus.req_rw_i = '0;
    bus.req_addr_i = '0;
    bus.req_data_i = '0;
    bus.req_id_i = '0;
    bus.c_stall_i = 1'b0;
    bus.c_ready_i = 1'b0;
    bus.c_data_i = '0;
    bus.c_id_i = '0;
    reset = 1'b0;
    tick();
    tick();
    check("rst_outputs", 72'({bus.c_valid_o, bus.req_stall_o, bus.rsp_ready_o, bus.err_o, bus.c_addr_o}), 72'(0));
    reset = 1'b1;
    tick();
    // single write from requester 0
    set_req(0, 1'b1, 32'd97, 32'd8, 3'd2);
    tick();
    bus.req_valid_i[0] = 1'b0;
    check("t1_stall_hi", 72'(bus.req_stall_o[0]), 72'(1));
    check("t1_cv_early", 72'(bus.c_valid_o), 72'(0));
    tick();
    check("t1_req", 72'({bus.c_valid_o, bus.c_rw_o, bus.c_addr_o, bus.c_data_o, bus.c_id_o}),
          72'({1'b1, 1'b1, 32'd97, 32'd8, 5'd2}));
    check("t1_stall_lo", 72'(bus.req_stall_o[0]), 72'(0));
    tick();
    check("t1_cv_drop", 72'(bus.c_valid_o), 72'(0));
    do_reset();
    // all four requesters at once
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 3'(k + 1));
    tick();
    bus.req_valid_i = '0;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      check("t2_order", 72'({bus.c_valid_o, bus.c_id_o, bus.c_addr_o}), 72'({1'b1, 2'(k), 3'(k + 1), 32'h100 + 32'(4 * k)}));
    end
    set_req(3, 1'b0, 32'h200, 32'h0, 3'd6);
    set_req(0, 1'b0, 32'h204, 32'h0, 3'd7);
    tick();
    bus.req_valid_i = '0;
    tick();
    check("t2_ptr_wrap", 72'({bus.c_valid_o, bus.c_id_o}), 72'({1'b1, 2'd0, 3'd7}));
    tick();
    check("t2_ptr_next", 72'({bus.c_valid_o, bus.c_id_o}), 72'({1'b1, 2'd3, 3'd6}));
    tick();
    check("t2_idle", 72'(bus.c_valid_o), 72'(0));
    // cache stall freezes the output stage
    set_req(0, 1'b1, 32'h300, 32'h55, 3'd1);
    set_req(1, 1'b0, 32'h310, 32'h0, 3'd2);
    tick();
    bus.req_valid_i = '0;
    tick();
    bus.c_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_frozen", 72'({bus.c_valid_o, bus.c_rw_o, bus.c_addr_o, bus.c_data_o, bus.c_id_o}),
            72'({1'b1, 1'b1, 32'h300, 32'h55, 2'd0, 3'd1}));
      check("t3_hold", 72'(bus.req_stall_o[1]), 72'(1));
    end
    bus.c_stall_i = 1'b0;
    tick();
    check("t3_next", 72'({bus.c_valid_o, bus.c_id_o, bus.c_addr_o}), 72'({1'b1, 2'd1, 3'd2, 32'h310}));
    tick();
    check("t3_idle", 72'(bus.c_valid_o), 72'(0));
    // response demux
    bus.c_ready_i = 1'b1;
    bus.c_id_i = {2'd2, 3'd5};
    bus.c_data_i = 32'h1234;
    tick();
    bus.c_ready_i = 1'b0;
    bus.c_data_i = 32'hDEAD;
    bus.c_id_i = {2'd0, 3'd1};
    check("t4_rsp", 72'({bus.rsp_ready_o, bus.rsp_id_o, bus.rsp_data_o}), 72'({4'b0100, 3'd5, 32'h1234}));
    tick();
    check("t4_rsp_hold", 72'({bus.rsp_ready_o, bus.rsp_id_o, bus.rsp_data_o}), 72'({4'b0000, 3'd5, 32'h1234}));
    check("t4_no_err", 72'(bus.err_o), 72'(0));
    do_reset();
    // outstanding limit on requester 1
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 10 && bus.req_stall_o[1]; i++) tick();
      set_req(1, 1'b0, 32'h500 + 32'(n), 32'h0, 3'(n));
      tick();
      bus.req_valid_i[1] = 1'b0;
    end
    repeat (4) tick();
    check("t5_held", 72'(bus.req_stall_o[1]), 72'(1));
    set_req(3, 1'b1, 32'h530, 32'h77, 3'd6);
    tick();
    bus.req_valid_i[3] = 1'b0;
    wait_owner(3, f);
    check("t5_other_granted", 72'(f), 72'(1));
    check("t5_still_held", 72'(bus.req_stall_o[1]), 72'(1));
    bus.c_ready_i = 1'b1;
    bus.c_id_i = {2'd1, 3'd0};
    tick();
    bus.c_ready_i = 1'b0;
    wait_owner(1, f);
    check("t5_released", 72'(f), 72'(1));
    check("t5_rel_id", 72'(bus.c_id_o[2:0]), 72'(4));
    repeat (3) tick();
    // asynchronous reset mid-burst
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 32'h600 + 32'(k), 32'h1, 3'(k));
    tick();
    bus.req_valid_i = '0;
    tick();
    check("t6_cv_before", 72'(bus.c_valid_o), 72'(1));
    reset = 1'b0;
    #1;
    check("t6_async_c", 72'({bus.c_valid_o, bus.c_rw_o, bus.c_addr_o, bus.c_id_o}), 72'(0));
    check("t6_async_rsp", 72'({bus.req_stall_o, bus.rsp_ready_o, bus.rsp_id_o, bus.rsp_data_o, bus.err_o}), 72'(0));
    clear_sb();
    tick();
    reset = 1'b1;
    set_req(2, 1'b0, 32'h700, 32'h0, 3'd1);
    set_req(0, 1'b0, 32'h704, 32'h0, 3'd2);
    tick();
    bus.req_valid_i = '0;
    tick();
    check("t6_first_r0", 72'({bus.c_valid_o, bus.c_id_o}), 72'({1'b1, 2'd0, 3'd2}));
    tick();
    check("t6_second_r2", 72'({bus.c_valid_o, bus.c_id_o}), 72'({1'b1, 2'd2, 3'd1}));
    bus.c_ready_i = 1'b1;
    bus.c_id_i = {2'd3, 3'd4};
    bus.c_data_i = 32'h99;
    tick();
    bus.c_ready_i = 1'b0;
    check("t6_err", 72'({bus.err_o, bus.rsp_ready_o}), 72'({1'b1, 4'b1000}));
    tick();
    check("t6_err_sticky", 72'(bus.err_o), 72'(1));
    do_reset();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_random(1'b1);
      tick();
    end
    for (int c = 0; c < 500 && (exp_q.size() > 0 || outs.size() > 0 || rsp_q.size() > 0); c++) begin
      drive_random(1'b0);
      tick();
    end
    bus.req_valid_i = '0;
    bus.c_ready_i = 1'b0;
    bus.c_stall_i = 1'b0;
    tick();
    tick();
    check("drain_req", 72'(exp_q.size()), 72'(0));
    check("drain_rsp", 72'(outs.size() + rsp_q.size()), 72'(0));
    check("rand_no_err", 72'(bus.err_o), 72'(0));
    check("rand_idle", 72'({bus.c_valid_o, bus.req_stall_o}), 72'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
